// File: rtl/everloop_pkg.sv
// Shared definitions for the Everloop LED ring: frame FSM states, pulse-width
// conversion helpers and the GRBW byte-lane layout used by wb_everloop.
package everloop_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        LATCH = 3'd4
    } state_t;

    // Byte-lane LSB positions inside one 32-bit LED word (sent MSB first).
    localparam int LANE_G   = 24;
    localparam int LANE_R   = 16;
    localparam int LANE_B   = 8;
    localparam int LANE_W   = 0;
    localparam int LED_BITS = 32;

    function automatic int ns_to_cycles(input int freq_hz, input int ns);
        return (freq_hz / 1000000) * ns / 1000;
    endfunction

    function automatic int us_to_cycles(input int freq_hz, input int us);
        return (freq_hz / 1000000) * us;
    endfunction

endpackage

// File: rtl/ws2812_bit_gen.sv
// One NRZ bit cell: a free-running phase counter while go is high, with the
// pin driven high for the first T0H or T1H cycles of every bit period.
module ws2812_bit_gen #(
    parameter int BIT_CYC = 60,
    parameter int T0H_CYC = 15,
    parameter int T1H_CYC = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic bit_val,
    output logic led_ctl,
    output logic bit_start,
    output logic bit_end
);

    localparam int PW  = $clog2(BIT_CYC);
    localparam int PW1 = PW + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(BIT_CYC - 1);
    localparam logic [PW:0]   HI0        = PW1'(T0H_CYC);
    localparam logic [PW:0]   HI1        = PW1'(T1H_CYC);

    logic [PW-1:0] phase;

    assign bit_start = go && (phase == '0);
    assign bit_end   = go && (phase == LAST_PHASE);

    // The pin reflects the phase one cycle late; every bit keeps its full width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= '0;
            led_ctl <= 1'b0;
        end else if (go) begin
            phase   <= bit_end ? '0 : phase + 1'b1;
            led_ctl <= ({1'b0, phase} < (bit_val ? HI1 : HI0));
        end else begin
            phase   <= '0;
            led_ctl <= 1'b0;
        end
    end

endmodule

// File: rtl/everloop_ws2812_tx.sv
// Everloop ring serial driver: fetches one GRBW word per LED from the LED
// buffer and streams it as WS2812/SK6812 NRZ bits, ending with a latch period.
module everloop_ws2812_tx
    import everloop_pkg::*;
#(
    parameter int clk_freq = 50000000,
    parameter int num_leds = 35,
    parameter int t0h_ns   = 300,
    parameter int t1h_ns   = 600,
    parameter int bit_ns   = 1200,
    parameter int latch_us = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  mem_adr,
    output logic        mem_rd,
    input  logic [31:0] mem_dat,
    output logic        led_ctl,
    output state_t      state
);

    localparam int T0H_CYC   = ns_to_cycles(clk_freq, t0h_ns);
    localparam int T1H_CYC   = ns_to_cycles(clk_freq, t1h_ns);
    localparam int BIT_CYC   = ns_to_cycles(clk_freq, bit_ns);
    localparam int LATCH_CYC = us_to_cycles(clk_freq, latch_us);
    localparam int LW        = $clog2(LATCH_CYC + 1);

    localparam logic [7:0]    LAST_LED  = 8'(num_leds - 1);
    localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYC);

    logic [31:0]   shreg;
    logic [31:0]   hold;
    logic [4:0]    bit_cnt;
    logic [7:0]    led_cnt;
    logic [LW-1:0] latch_cnt;
    logic          rd_pend;
    logic          go;
    logic          bit_start;
    logic          bit_end;

    assign go = (state == SHIFT);

    ws2812_bit_gen #(
        .BIT_CYC (BIT_CYC),
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC)
    ) u_bit_gen (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .bit_val   (shreg[31]),
        .led_ctl   (led_ctl),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_adr   <= 8'd0;
            shreg     <= 32'd0;
            hold      <= 32'd0;
            bit_cnt   <= 5'd0;
            led_cnt   <= 8'd0;
            latch_cnt <= '0;
            rd_pend   <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            done    <= 1'b0;
            // Prefetched word arrives one cycle after the read strobe.
            rd_pend <= mem_rd && (state == SHIFT);
            if (rd_pend) begin
                hold <= mem_dat;
            end

            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        mem_rd  <= 1'b1;
                        mem_adr <= 8'd0;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg   <= mem_dat;
                    bit_cnt <= 5'd31;
                    led_cnt <= 8'd0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_start && (bit_cnt == 5'd0) && (led_cnt != LAST_LED)) begin
                        mem_rd  <= 1'b1;
                        mem_adr <= led_cnt + 8'd1;
                    end
                    if (bit_end) begin
                        if (bit_cnt != 5'd0) begin
                            shreg   <= {shreg[30:0], 1'b0};
                            bit_cnt <= bit_cnt - 5'd1;
                        end else if (led_cnt == LAST_LED) begin
                            latch_cnt <= '0;
                            state     <= LATCH;
                        end else begin
                            shreg   <= hold;
                            bit_cnt <= 5'd31;
                            led_cnt <= led_cnt + 8'd1;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_END) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_everloop_ws2812_tx.sv
// Directed bench for everloop_ws2812_tx: four instances cover 1, 2 and 35 LEDs
// at 50 MHz plus a 100 MHz single-LED variant.
module tb_everloop_ws2812_tx;
    import everloop_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n   [4];
    logic        start   [4];
    logic        busy    [4];
    logic        done    [4];
    logic [7:0]  mem_adr [4];
    logic        mem_rd  [4];
    logic [31:0] mem_dat [4];
    logic        led     [4];
    state_t      st      [4];

    int tests_run    = 0;
    int tests_failed = 0;

    int rise_q   [4][$];
    int fall_q   [4][$];
    int rd_cyc_q [4][$];
    int rd_adr_q [4][$];
    int busy_err [4];

    int td_big, nd_big, td_s, nd_s;

    always #5 clk = ~clk;

    everloop_ws2812_tx #(.num_leds(1)) dut_one (
        .clk(clk), .rst(rst_n[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .mem_adr(mem_adr[0]), .mem_rd(mem_rd[0]), .mem_dat(mem_dat[0]), .led_ctl(led[0]), .state(st[0]));

    everloop_ws2812_tx #(.num_leds(2)) dut_two (
        .clk(clk), .rst(rst_n[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .mem_adr(mem_adr[1]), .mem_rd(mem_rd[1]), .mem_dat(mem_dat[1]), .led_ctl(led[1]), .state(st[1]));

    everloop_ws2812_tx dut_def (
        .clk(clk), .rst(rst_n[2]), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .mem_adr(mem_adr[2]), .mem_rd(mem_rd[2]), .mem_dat(mem_dat[2]), .led_ctl(led[2]), .state(st[2]));

    everloop_ws2812_tx #(.clk_freq(100000000), .num_leds(1)) dut_fast (
        .clk(clk), .rst(rst_n[3]), .start(start[3]), .busy(busy[3]), .done(done[3]),
        .mem_adr(mem_adr[3]), .mem_rd(mem_rd[3]), .mem_dat(mem_dat[3]), .led_ctl(led[3]), .state(st[3]));

    function automatic logic [31:0] model_word(input int d, input int a);
        logic [7:0] b;
        b = a[7:0];
        case (d)
            1:       return (a == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            2:       return {b, ~b, 8'h5A, b ^ 8'hC3};
            default: return 32'h8000_0000;
        endcase
    endfunction

    // LED buffer: data valid only in the cycle after a read strobe.
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            mem_dat[g] <= mem_rd[g] ? model_word(g, int'(mem_adr[g])) : 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start, then record pin edges, reads and done relative to the start cycle.
    task automatic run_frame(input int d, input int limit, input int extra_start,
                             input int rst_at, output int t_done, output int n_done);
        logic prev;
        logic exp_busy;
        t_done = -1;
        n_done = 0;
        busy_err[d] = 0;
        rise_q[d].delete();
        fall_q[d].delete();
        rd_cyc_q[d].delete();
        rd_adr_q[d].delete();
        @(negedge clk);
        prev = led[d];
        start[d] = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            start[d] = (n == extra_start);
            if (led[d] && !prev) rise_q[d].push_back(n);
            if (!led[d] && prev) fall_q[d].push_back(n);
            prev = led[d];
            if (mem_rd[d]) begin
                rd_cyc_q[d].push_back(n);
                rd_adr_q[d].push_back(int'(mem_adr[d]));
            end
            if (done[d]) begin
                n_done++;
                if (t_done < 0) t_done = n;
            end
            exp_busy = (t_done < 0);
            if (busy[d] !== exp_busy) busy_err[d]++;
            if (n == rst_at) begin
                check_eq("led_before_rst", longint'(led[d]), 1);
                rst_n[d] = 1'b0;
                #1;
                check_eq("led_in_rst", longint'(led[d]), 0);
                check_eq("busy_in_rst", longint'(busy[d]), 0);
                check_eq("rd_in_rst", longint'(mem_rd[d]), 0);
                check_eq("done_in_rst", longint'(done[d]), 0);
                break;
            end
            if (t_done >= 0 && n >= t_done + 20) break;
        end
    endtask

    // Compare the recorded frame against the bench's word model and bit timing.
    task automatic check_stream(input string tag, input int d, input int nleds,
                                input int t0, input int t1, input int per);
        int errs_r, errs_h, errs_rd, idx;
        logic [31:0] w;
        errs_r = 0; errs_h = 0; errs_rd = 0;
        check_eq({tag, "_rises"}, rise_q[d].size(), nleds * 32);
        check_eq({tag, "_falls"}, fall_q[d].size(), nleds * 32);
        if (rise_q[d].size() == nleds * 32 && fall_q[d].size() == nleds * 32) begin
            for (int i = 0; i < nleds * 32; i++) begin
                w = model_word(d, i / 32);
                if (rise_q[d][i] != 4 + i * per) errs_r++;
                if (fall_q[d][i] - rise_q[d][i] != (w[31 - (i % 32)] ? t1 : t0)) errs_h++;
            end
        end
        check_eq({tag, "_rise_pos_errs"}, errs_r, 0);
        check_eq({tag, "_high_errs"}, errs_h, 0);
        check_eq({tag, "_reads"}, rd_cyc_q[d].size(), nleds);
        if (rd_cyc_q[d].size() == nleds) begin
            for (int k = 0; k < nleds; k++) begin
                idx = (k == 0) ? 1 : 4 + ((k - 1) * 32 + 31) * per;
                if (rd_cyc_q[d][k] != idx || rd_adr_q[d][k] != k) errs_rd++;
            end
        end
        check_eq({tag, "_read_errs"}, errs_rd, 0);
        check_eq({tag, "_busy_errs"}, busy_err[d], 0);
    endtask

    initial begin
        int quiet_err;
        for (int d = 0; d < 4; d++) begin
            start[d] = 1'b0;
            rst_n[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check_eq("rst_led", longint'(led[d]), 0);
            check_eq("rst_busy", longint'(busy[d]), 0);
            check_eq("rst_done", longint'(done[d]), 0);
            check_eq("rst_rd", longint'(mem_rd[d]), 0);
            check_eq("rst_adr", longint'(mem_adr[d]), 0);
            check_eq("rst_state", longint'(st[d]), longint'(IDLE));
        end

        fork
            begin
                run_frame(2, 72000, -1, -1, td_big, nd_big);
                check_eq("def_done_cycle", td_big, 71204);
                check_eq("def_done_count", nd_big, 1);
                check_stream("def", 2, 35, 15, 30, 60);
            end
            begin
                // Single LED, start repeated in the done cycle.
                run_frame(0, 6500, 5924, -1, td_s, nd_s);
                check_eq("one_first_rise", rise_q[0].size() > 0 ? rise_q[0][0] : -1, 4);
                check_eq("one_bit0_high", fall_q[0].size() > 0 ? fall_q[0][0] - rise_q[0][0] : -1, 30);
                check_eq("one_bit1_high", fall_q[0].size() > 1 ? fall_q[0][1] - rise_q[0][1] : -1, 15);
                check_eq("one_done_cycle", td_s, 5924);
                check_eq("one_done_count", nd_s, 1);
                check_stream("one", 0, 1, 15, 30, 60);

                // Two LEDs with a second start mid-frame.
                run_frame(1, 9000, 1000, -1, td_s, nd_s);
                check_eq("two_led_gap", rise_q[1].size() > 32 ? rise_q[1][32] - rise_q[1][31] : -1, 60);
                check_eq("two_prefetch_cycle", rd_cyc_q[1].size() > 1 ? rd_cyc_q[1][1] : -1, 1864);
                check_eq("two_done_cycle", td_s, 7844);
                check_eq("two_done_count", nd_s, 1);
                check_stream("two", 1, 2, 15, 30, 60);

                // Reset mid-bit, then a clean frame.
                run_frame(1, 9000, -1, 500, td_s, nd_s);
                quiet_err = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (led[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) quiet_err++;
                end
                rst_n[1] = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (led[1] !== 1'b0 || busy[1] !== 1'b0 || done[1] !== 1'b0) quiet_err++;
                end
                check_eq("rst_quiet_errs", quiet_err, 0);
                check_eq("rst_state_idle", longint'(st[1]), longint'(IDLE));
                run_frame(1, 9000, -1, -1, td_s, nd_s);
                check_eq("rerun_done_cycle", td_s, 7844);
                check_eq("rerun_done_count", nd_s, 1);
                check_stream("rerun", 1, 2, 15, 30, 60);

                // 100 MHz: all widths double.
                run_frame(3, 13000, -1, -1, td_s, nd_s);
                check_eq("fast_bit0_high", fall_q[3].size() > 0 ? fall_q[3][0] - rise_q[3][0] : -1, 60);
                check_eq("fast_bit1_high", fall_q[3].size() > 1 ? fall_q[3][1] - rise_q[3][1] : -1, 30);
                check_eq("fast_period", rise_q[3].size() > 1 ? rise_q[3][1] - rise_q[3][0] : -1, 120);
                check_eq("fast_latch", fall_q[3].size() == 32 ? td_s - (rise_q[3][31] + 120) : -1, 8000);
                check_eq("fast_done_cycle", td_s, 11844);
                check_stream("fast", 3, 1, 30, 60, 120);
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
